// File: rtl/pwm_pkg.sv
// ============================================================
// pwm_pkg : shared types and defaults for the PWM capture block
// Rev 1.0
// ============================================================
`default_nettype none

package pwm_pkg;

  localparam int DUTY_W      = 8;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pwm_div.sv
// ============================================================
// pwm_div : sequential restoring divider, floor(high*256/period)
// Rev 1.0
// ============================================================
`default_nettype none

module pwm_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_abort,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_high,
  input  logic [CNT_W-1:0]  i_period,
  output logic              o_busy,
  output logic              o_done,
  output logic [DUTY_W-1:0] o_quot
);

  localparam logic [3:0] C_ITER = 4'(DUTY_W);

  logic [CNT_W-1:0]  r_rem;
  logic [CNT_W-1:0]  r_dvs;
  logic [DUTY_W-1:0] r_q;
  logic [DUTY_W-1:0] r_quot;
  logic [3:0]        r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_sat;
  logic [CNT_W:0]    w_shift;
  logic [CNT_W-1:0]  w_diff;
  logic              w_ge;

  // Remainder stays below the divisor, so the shifted value fits CNT_W+1 bits
  // and the difference always fits CNT_W bits.
  assign w_shift = {r_rem, 1'b0};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_diff  = w_shift[CNT_W-1:0] - r_dvs;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_dvs  <= '0;
      r_q    <= '0;
      r_quot <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_sat  <= 1'b0;
    end else if (i_abort) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start && !r_busy) begin
        r_rem  <= i_high;
        r_dvs  <= i_period;
        r_q    <= '0;
        r_cnt  <= '0;
        r_sat  <= (i_high >= i_period);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        if (r_cnt == C_ITER) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_quot <= r_sat ? '1 : r_q;
        end else begin
          r_rem <= w_ge ? w_diff : w_shift[CNT_W-1:0];
          r_q   <= {r_q[DUTY_W-2:0], w_ge};
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy | r_done;
  assign o_done = r_done;
  assign o_quot = r_quot;

endmodule

`default_nettype wire

// File: rtl/pwm_capture.sv
// ============================================================
// pwm_capture : PWM period / high-time / duty capture with timeout
// Rev 1.0
// ============================================================
`default_nettype none

module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              en,
  input  logic              pwm_in,
  input  logic              pwm_comp_in,
  input  logic              clr_err,
  output logic [DUTY_W-1:0] duty_out,
  output logic [CNT_W-1:0]  period_out,
  output logic [CNT_W-1:0]  high_out,
  output logic              valid,
  output logic              overlap_err,
  output logic              ovr_err
);

  localparam int               TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  logic [1:0]        r_sync_p;
  logic [1:0]        r_sync_c;
  logic              r_lvl;
  logic              r_rise;
  state_e            r_state;
  logic [TO_W-1:0]   r_to;
  logic [CNT_W-1:0]  r_per;
  logic [CNT_W-1:0]  r_hi;
  logic [CNT_W-1:0]  r_lat_per;
  logic [CNT_W-1:0]  r_lat_hi;
  logic [DUTY_W-1:0] r_duty;
  logic [CNT_W-1:0]  r_period;
  logic [CNT_W-1:0]  r_high;
  logic              r_valid;
  logic              r_ovl;
  logic              r_ovr;

  logic              w_close;
  logic              w_start;
  logic              w_timeout;
  logic              w_busy;
  logic              w_done;
  logic [DUTY_W-1:0] w_quot;

  // r_lvl is the synced level delayed to line up with r_rise.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sync_p <= '0;
      r_sync_c <= '0;
      r_lvl    <= 1'b0;
      r_rise   <= 1'b0;
    end else begin
      r_sync_p <= {r_sync_p[0], pwm_in};
      r_sync_c <= {r_sync_c[0], pwm_comp_in};
      r_lvl    <= r_sync_p[1];
      r_rise   <= r_sync_p[1] & ~r_lvl;
    end
  end

  assign w_close   = en && (r_state == ST_MEAS) && r_rise;
  assign w_start   = w_close && !w_busy;
  assign w_timeout = en && (r_state != ST_IDLE) && !r_rise &&
                     (r_to == TO_W'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= ST_IDLE;
      r_to      <= '0;
      r_per     <= '0;
      r_hi      <= '0;
      r_lat_per <= '0;
      r_lat_hi  <= '0;
      r_duty    <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_valid   <= 1'b0;
      r_ovl     <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!en) begin
        r_state <= ST_IDLE;
        r_to    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_ARM;
            r_to    <= '0;
          end
          ST_ARM, ST_MEAS: begin
            if (r_rise) begin
              // The edge cycle opens the next window.
              r_state <= ST_MEAS;
              r_to    <= '0;
              r_per   <= C_CNT_ONE;
              r_hi    <= C_CNT_ONE;
              if (w_start) begin
                r_lat_per <= r_per;
                r_lat_hi  <= r_hi;
              end
            end else if (w_timeout) begin
              r_state <= ST_ARM;
              r_to    <= '0;
            end else begin
              r_to <= r_to + 1'b1;
              if (r_per != C_CNT_MAX) r_per <= r_per + 1'b1;
              if (r_lvl && (r_hi != C_CNT_MAX)) r_hi <= r_hi + 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end

      if (w_timeout) begin
        r_valid  <= 1'b1;
        r_period <= '0;
        r_high   <= '0;
        r_duty   <= {DUTY_W{r_lvl}};
      end else if (w_done && en) begin
        r_valid  <= 1'b1;
        r_period <= r_lat_per;
        r_high   <= r_lat_hi;
        r_duty   <= w_quot;
      end

      r_ovl <= (r_sync_p[1] & r_sync_c[1]) | (r_ovl & ~clr_err);
      r_ovr <= (w_close & w_busy) | (r_ovr & ~clr_err);
    end
  end

  pwm_div #(
    .CNT_W (CNT_W)
  ) u_div (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .i_abort  (~en),
    .i_start  (w_start),
    .i_high   (r_hi),
    .i_period (r_per),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_quot   (w_quot)
  );

  assign duty_out    = r_duty;
  assign period_out  = r_period;
  assign high_out    = r_high;
  assign valid       = r_valid;
  assign overlap_err = r_ovl;
  assign ovr_err     = r_ovr;

endmodule

`default_nettype wire
